// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the memory-mapped IO bus.
// Each transaction issues one io_mreq cycle, then a single ack (or err for illegal addresses).
module io_bus_arbiter #(
    parameter logic [31:0] IO_BASE = 32'hFFFF_FFF0,
    parameter logic [31:0] IO_MASK = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic [31:0] io_a,
    output logic [31:0] io_wd,
    output logic        io_we,
    output logic        io_mreq,
    input  logic [31:0] io_rdata,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        ACK    = 2'b10,
        ERR    = 2'b11
    } state_t;

    state_t      state_r;
    state_t      next_state_s;

    logic [31:0] io_a_r;
    logic [31:0] io_wd_r;
    logic        io_we_r;
    logic        io_mreq_r;
    logic        m0_ack_r;
    logic        m1_ack_r;
    logic        m0_err_r;
    logic        m1_err_r;
    logic [31:0] m0_rdata_r;
    logic [31:0] m1_rdata_r;
    logic        busy_r;
    logic        owner_r;
    logic        prio_r;

    logic        any_req_s;
    logic        grant_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic        sel_we_s;
    logic        legal_s;
    logic        owner_next_s;

    function automatic logic addr_legal(input logic [31:0] addr);
        addr_legal = ((addr & IO_MASK) == IO_BASE) && (addr[1:0] == 2'b00);
    endfunction

    // Arbitration: single requester wins outright, a tie goes to the master not served last.
    always_comb begin
        any_req_s = m0_req | m1_req;
        grant_s   = 1'b0;
        if (m0_req && m1_req) begin
            grant_s = prio_r;
        end else if (m1_req) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        sel_addr_s  = grant_s ? m1_addr  : m0_addr;
        sel_wdata_s = grant_s ? m1_wdata : m0_wdata;
        sel_we_s    = grant_s ? m1_we    : m0_we;
        legal_s     = addr_legal(sel_addr_s);
        if (state_r == IDLE && any_req_s) begin
            owner_next_s = grant_s;
        end else begin
            owner_next_s = owner_r;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    next_state_s = legal_s ? ACCESS : ERR;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS:  next_state_s = ACK;
            ACK:     next_state_s = IDLE;
            ERR:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register plus strobes registered from the upcoming state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            io_mreq_r <= 1'b0;
            m0_ack_r  <= 1'b0;
            m1_ack_r  <= 1'b0;
            m0_err_r  <= 1'b0;
            m1_err_r  <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            busy_r    <= (next_state_s != IDLE);
            io_mreq_r <= (next_state_s == ACCESS);
            m0_ack_r  <= (next_state_s == ACK) && !owner_next_s;
            m1_ack_r  <= (next_state_s == ACK) &&  owner_next_s;
            m0_err_r  <= (next_state_s == ERR) && !owner_next_s;
            m1_err_r  <= (next_state_s == ERR) &&  owner_next_s;
        end
    end

    // Grant bookkeeping and latched bus fields; fields hold until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_a_r  <= 32'h0000_0000;
            io_wd_r <= 32'h0000_0000;
            io_we_r <= 1'b0;
            owner_r <= 1'b0;
            prio_r  <= 1'b0;
        end else if (state_r == IDLE && any_req_s) begin
            io_a_r  <= sel_addr_s;
            io_wd_r <= sel_wdata_s;
            io_we_r <= sel_we_s;
            owner_r <= grant_s;
            prio_r  <= ~grant_s;
        end
    end

    // Read data capture at the closing edge of the access cycle, into the owner's register only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rdata_r <= 32'h0000_0000;
            m1_rdata_r <= 32'h0000_0000;
        end else if (state_r == ACCESS && !io_we_r) begin
            if (owner_r) begin
                m1_rdata_r <= io_rdata;
            end else begin
                m0_rdata_r <= io_rdata;
            end
        end
    end

    assign io_a     = io_a_r;
    assign io_wd    = io_wd_r;
    assign io_we    = io_we_r;
    assign io_mreq  = io_mreq_r;
    assign m0_ack   = m0_ack_r;
    assign m1_ack   = m1_ack_r;
    assign m0_err   = m0_err_r;
    assign m1_err   = m1_err_r;
    assign m0_rdata = m0_rdata_r;
    assign m1_rdata = m1_rdata_r;
    assign busy     = busy_r;
    assign owner    = owner_r;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: hand-computed expectations checked with immediate assertions.
module tb_io_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_we;
    logic        m0_ack;
    logic        m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_we;
    logic        m1_ack;
    logic        m1_err;
    logic [31:0] m1_rdata;
    logic [31:0] io_a;
    logic [31:0] io_wd;
    logic        io_we;
    logic        io_mreq;
    logic [31:0] io_rdata;
    logic        busy;
    logic        owner;

    int checks;
    int errors;

    io_bus_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_we    (m0_we),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_we    (m1_we),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .m1_rdata (m1_rdata),
        .io_a     (io_a),
        .io_wd    (io_wd),
        .io_we    (io_we),
        .io_mreq  (io_mreq),
        .io_rdata (io_rdata),
        .busy     (busy),
        .owner    (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        m0_req   = 1'b0;
        m0_addr  = 32'h0000_0000;
        m0_wdata = 32'h0000_0000;
        m0_we    = 1'b0;
        m1_req   = 1'b0;
        m1_addr  = 32'h0000_0000;
        m1_wdata = 32'h0000_0000;
        m1_we    = 1'b0;
        io_rdata = 32'h0000_0000;
        tick();
        tick();
        chk("rst_mreq", {31'd0, io_mreq}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_owner", {31'd0, owner}, 32'd0);
        rst = 1'b0;
        tick();

        // m0 read of the switch register
        m0_req   = 1'b1;
        m0_addr  = 32'hFFFF_FFF0;
        m0_we    = 1'b0;
        io_rdata = 32'h0000_00A5;
        tick();
        chk("t2_mreq", {31'd0, io_mreq}, 32'd1);
        chk("t2_io_a", io_a, 32'hFFFF_FFF0);
        chk("t2_io_we", {31'd0, io_we}, 32'd0);
        chk("t2_owner", {31'd0, owner}, 32'd0);
        chk("t2_busy", {31'd0, busy}, 32'd1);
        chk("t2_early_ack", {31'd0, m0_ack}, 32'd0);
        tick();
        chk("t2_ack", {31'd0, m0_ack}, 32'd1);
        chk("t2_mreq_off", {31'd0, io_mreq}, 32'd0);
        chk("t2_m0_rdata", m0_rdata, 32'h0000_00A5);
        chk("t2_m1_rdata", m1_rdata, 32'h0000_0000);
        m0_req = 1'b0;
        tick();
        chk("t2_ack_pulse", {31'd0, m0_ack}, 32'd0);
        chk("t2_idle", {31'd0, busy}, 32'd0);

        // m1 write to the 7-segment register; io_rdata must not be captured
        m1_req   = 1'b1;
        m1_addr  = 32'hFFFF_FFF8;
        m1_wdata = 32'h0000_007B;
        m1_we    = 1'b1;
        io_rdata = 32'h0000_0055;
        tick();
        chk("t3_mreq", {31'd0, io_mreq}, 32'd1);
        chk("t3_io_we", {31'd0, io_we}, 32'd1);
        chk("t3_io_wd", io_wd, 32'h0000_007B);
        chk("t3_io_a", io_a, 32'hFFFF_FFF8);
        chk("t3_owner", {31'd0, owner}, 32'd1);
        tick();
        chk("t3_m1_ack", {31'd0, m1_ack}, 32'd1);
        chk("t3_m0_ack", {31'd0, m0_ack}, 32'd0);
        chk("t3_m1_rdata", m1_rdata, 32'h0000_0000);
        chk("t3_m0_rdata", m0_rdata, 32'h0000_00A5);
        m1_req = 1'b0;
        tick();
        chk("t3_hold_io_a", io_a, 32'hFFFF_FFF8);
        chk("t3_hold_io_we", {31'd0, io_we}, 32'd1);

        // reset with idle bus, asynchronous
        #2;
        rst = 1'b1;
        #1;
        chk("t1_io_we", {31'd0, io_we}, 32'd0);
        chk("t1_io_a", io_a, 32'd0);
        chk("t1_io_wd", io_wd, 32'd0);
        chk("t1_m0_rdata", m0_rdata, 32'd0);
        chk("t1_owner", {31'd0, owner}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);

        // both masters requesting continuously from reset
        m0_req   = 1'b1;
        m0_addr  = 32'hFFFF_FFF0;
        m0_we    = 1'b0;
        m1_req   = 1'b1;
        m1_addr  = 32'hFFFF_FFF0;
        m1_we    = 1'b0;
        io_rdata = 32'h0000_0011;
        tick();
        rst = 1'b0;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("t4_owner", {31'd0, owner}, g % 2);
            chk("t4_mreq", {31'd0, io_mreq}, 32'd1);
            tick();
            chk("t4_m0_ack", {31'd0, m0_ack}, (g % 2 == 0) ? 32'd1 : 32'd0);
            chk("t4_m1_ack", {31'd0, m1_ack}, (g % 2 == 1) ? 32'd1 : 32'd0);
            if (g == 3) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            tick();
            chk("t4_idle_mreq", {31'd0, io_mreq}, 32'd0);
        end
        chk("t4_m0_rdata", m0_rdata, 32'h0000_0011);
        chk("t4_m1_rdata", m1_rdata, 32'h0000_0011);

        // illegal addresses: out of window, then misaligned
        io_rdata = 32'h0000_00EE;
        m0_req   = 1'b1;
        m0_addr  = 32'h0000_1000;
        tick();
        chk("t5a_err", {31'd0, m0_err}, 32'd1);
        chk("t5a_mreq", {31'd0, io_mreq}, 32'd0);
        chk("t5a_ack", {31'd0, m0_ack}, 32'd0);
        m0_req = 1'b0;
        tick();
        chk("t5a_err_pulse", {31'd0, m0_err}, 32'd0);
        chk("t5a_mreq2", {31'd0, io_mreq}, 32'd0);
        m0_req  = 1'b1;
        m0_addr = 32'hFFFF_FFF9;
        tick();
        chk("t5b_err", {31'd0, m0_err}, 32'd1);
        chk("t5b_mreq", {31'd0, io_mreq}, 32'd0);
        chk("t5b_m1_err", {31'd0, m1_err}, 32'd0);
        m0_req = 1'b0;
        tick();
        chk("t5b_err_pulse", {31'd0, m0_err}, 32'd0);
        chk("t5_m0_rdata", m0_rdata, 32'h0000_0011);

        // reset during the access cycle, then replay after release
        m0_req   = 1'b1;
        m0_addr  = 32'hFFFF_FFF0;
        io_rdata = 32'h0000_003C;
        tick();
        chk("t6_mreq", {31'd0, io_mreq}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_mreq", {31'd0, io_mreq}, 32'd0);
        chk("t6_async_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("t6_no_ack", {31'd0, m0_ack}, 32'd0);
        rst = 1'b0;
        tick();
        chk("t6_replay_mreq", {31'd0, io_mreq}, 32'd1);
        tick();
        chk("t6_replay_ack", {31'd0, m0_ack}, 32'd1);
        chk("t6_replay_rdata", m0_rdata, 32'h0000_003C);
        m0_req = 1'b0;
        tick();
        chk("t6_done", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
